// File: rtl/stage_mem.sv
`timescale 1ns/1ps
// Memory-access stage: issues loads/stores on a req/gnt/rvalid port, aligns load data, registers the WB bundle.
// Non-memory ops retire one cycle later; memory ops raise stall_o until grant (store) or response (load) arrives.
module stage_mem #(
  parameter int WD_SIZE     = 32,
  parameter int REG_SIZE    = 5,
  parameter int FUNCT3_SIZE = 3,
  parameter int BE_SIZE     = WD_SIZE/8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WD_SIZE-1:0]     alu_result_i,
  input  logic [WD_SIZE-1:0]     rs2_data_i,
  input  logic [REG_SIZE-1:0]    rd_i,
  input  logic                   ctrl_ld_i,
  input  logic                   ctrl_st_i,
  input  logic                   ctrl_reg_write_i,
  input  logic [FUNCT3_SIZE-1:0] ctrl_mem_width_i,
  output logic                   stall_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [WD_SIZE-1:0]     mem_addr_o,
  output logic [WD_SIZE-1:0]     mem_wdata_o,
  output logic [BE_SIZE-1:0]     mem_be_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [WD_SIZE-1:0]     mem_rdata_i,
  output logic [WD_SIZE-1:0]     wb_data_o,
  output logic [REG_SIZE-1:0]    wb_rd_o,
  output logic                   wb_reg_write_o,
  output logic                   wb_valid_o,
  output logic                   misaligned_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [1:0]             off;
    logic [FUNCT3_SIZE-1:0] width;
    logic [REG_SIZE-1:0]    rd;
    logic                   reg_write;
  } ld_ctx_t;

  localparam logic [1:0] W_B = 2'b00;
  localparam logic [1:0] W_H = 2'b01;

  state_t               state;
  ld_ctx_t              ctx;
  logic                 req_q;
  logic                 is_mem;
  logic                 misaligned;
  logic [1:0]           off;
  logic [BE_SIZE-1:0]   be;
  logic [WD_SIZE-1:0]   wdata;
  logic [WD_SIZE-1:0]   shifted;
  logic [WD_SIZE-1:0]   load_data;

  assign is_mem = ctrl_ld_i | ctrl_st_i;
  assign off    = alu_result_i[1:0];

  // Request drops in the same cycle reset is asserted, not one edge later.
  assign mem_req_o = req_q & reset_n;

  always_comb begin
    misaligned = 1'b0;
    be         = '1;
    wdata      = rs2_data_i;
    case (ctrl_mem_width_i[1:0])
      W_B: begin
        be    = BE_SIZE'(1) << off;
        wdata = {(WD_SIZE/8){rs2_data_i[7:0]}};
      end
      W_H: begin
        misaligned = off[0];
        be         = BE_SIZE'(3) << off;
        wdata      = {(WD_SIZE/16){rs2_data_i[15:0]}};
      end
      default: misaligned = (off != 2'b00);
    endcase
    misaligned = misaligned & is_mem;
  end

  assign shifted = mem_rdata_i >> {ctx.off, 3'b000};

  always_comb begin
    load_data = mem_rdata_i;
    case (ctx.width)
      3'b000:  load_data = {{(WD_SIZE-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(WD_SIZE-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(WD_SIZE-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(WD_SIZE-16){1'b0}}, shifted[15:0]};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE:    stall_o = is_mem & ~misaligned;
        REQ:     stall_o = ~(mem_gnt_i & mem_we_o);
        WAIT:    stall_o = ~mem_rvalid_i;
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ctx            <= '0;
      req_q          <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      mem_be_o       <= '0;
      wb_data_o      <= '0;
      wb_rd_o        <= '0;
      wb_reg_write_o <= 1'b0;
      wb_valid_o     <= 1'b0;
      misaligned_o   <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      misaligned_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_data_o      <= alu_result_i;
            wb_rd_o        <= rd_i;
            wb_reg_write_o <= ctrl_reg_write_i;
            wb_valid_o     <= 1'b1;
          end else if (misaligned) begin
            misaligned_o <= 1'b1;
            wb_valid_o   <= 1'b1;
          end else begin
            mem_addr_o    <= {alu_result_i[WD_SIZE-1:2], 2'b00};
            mem_be_o      <= be;
            mem_wdata_o   <= wdata;
            mem_we_o      <= ctrl_st_i;
            req_q         <= 1'b1;
            ctx.off       <= off;
            ctx.width     <= ctrl_mem_width_i;
            ctx.rd        <= rd_i;
            ctx.reg_write <= ctrl_reg_write_i;
            state         <= REQ;
          end
        end
        REQ: begin
          // A same-cycle rvalid is not ours: the response always follows the grant.
          if (mem_gnt_i) begin
            req_q <= 1'b0;
            if (mem_we_o) begin
              wb_valid_o <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            wb_data_o      <= load_data;
            wb_rd_o        <= ctx.rd;
            wb_reg_write_o <= ctx.reg_write & (ctx.rd != '0);
            wb_valid_o     <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
`timescale 1ns/1ps
// Directed bench for stage_mem: expected retirements and memory requests are queued at issue time
// and checked by independent monitors; a small responder models grant/response latency.
module tb_stage_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] alu_result_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        ctrl_ld_i, ctrl_st_i, ctrl_reg_write_i;
  logic [2:0]  ctrl_mem_width_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o, wb_valid_o, misaligned_o;

  stage_mem dut (
    .clk(clk), .reset_n(reset_n),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i), .ctrl_reg_write_i(ctrl_reg_write_i),
    .ctrl_mem_width_i(ctrl_mem_width_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_valid_o(wb_valid_o), .misaligned_o(misaligned_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chk;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic void push_wb(input logic [31:0] data, input logic [4:0] rd,
                                  input logic rw, input logic mis, input logic chk);
    wb_exp_t e;
    e.data = data; e.rd = rd; e.rw = rw; e.mis = mis; e.chk = chk;
    wb_q.push_back(e);
  endfunction

  function automatic void push_mem(input logic [31:0] addr, input logic we,
                                   input logic [3:0] be, input logic [31:0] wdata);
    mem_exp_t m;
    m.addr = addr; m.we = we; m.be = be; m.wdata = wdata;
    mem_q.push_back(m);
  endfunction

  // Memory responder: grant after gnt_delay REQ cycles, load data rv_delay cycles after grant.
  int          gnt_delay = 0;
  int          rv_delay = 1;
  bit          junk_rv = 0;
  logic [31:0] next_rdata = 32'h0;
  int          req_wait = 0, rv_wait = 0, rv_target = 0, req_seen = 0;
  bit          pending = 0;
  logic [31:0] held_rdata = 32'h0;

  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
      if (mem_req_o) begin
        req_seen++;
        if (junk_rv) mem_rvalid_i = 1'b1;
        if (req_wait >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          req_wait = 0;
          if (!mem_we_o) begin
            pending = 1; rv_wait = 1; rv_target = rv_delay; held_rdata = next_rdata;
          end
        end else begin
          req_wait++;
        end
      end else if (pending) begin
        if (rv_wait >= rv_target) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = held_rdata; pending = 0;
        end else begin
          rv_wait++;
        end
      end
    end
  end

  // Monitor: retirements and granted requests against the queued expectations.
  initial begin
    wb_exp_t  e;
    mem_exp_t m;
    forever begin
      @(negedge clk); #1;
      if (wb_valid_o === 1'b1) begin
        if (wb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wb_unexpected: wb_valid_o=1 with rd=%0d data=0x%08h, required no retirement", wb_rd_o, wb_data_o);
        end else begin
          e = wb_q.pop_front();
          check("wb_reg_write", 32'(wb_reg_write_o), 32'(e.rw));
          check("wb_misaligned", 32'(misaligned_o), 32'(e.mis));
          if (e.chk) begin
            check("wb_data", wb_data_o, e.data);
            check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
          end
        end
      end else if (misaligned_o === 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL misaligned_stray: actual 1 without wb_valid_o, required 0");
      end
      if (mem_req_o === 1'b1 && mem_gnt_i) begin
        if (mem_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mem_unexpected: request addr=0x%08h, required none", mem_addr_o);
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr_o, m.addr);
          check("mem_we", 32'(mem_we_o), 32'(m.we));
          check("mem_be", 32'(mem_be_o), 32'(m.be));
          if (m.we) check("mem_wdata", mem_wdata_o & lane_mask(mem_be_o), m.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic ld, input logic st, input logic rw, input logic [2:0] w);
    alu_result_i = a; rs2_data_i = d; rd_i = rd;
    ctrl_ld_i = ld; ctrl_st_i = st; ctrl_reg_write_i = rw; ctrl_mem_width_i = w;
  endtask

  // Counts stall cycles until the held instruction is accepted; returns at posedge+1.
  task automatic wait_accept(output int stalls);
    bit done;
    stalls = 0;
    done = 0;
    while (!done) begin
      @(negedge clk); #1;
      if (!stall_o) begin
        done = 1;
      end else begin
        stalls++;
        if (stalls > 40) begin
          vectors++; miscompares++;
          $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, required release", stalls);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                     input logic ld, input logic st, input logic rw, input logic [2:0] w,
                     output int stalls);
    drive(a, d, rd, ld, st, rw, w);
    wait_accept(stalls);
  endtask

  initial begin
    int st;
    int r0;
    reset_n = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_mem_we", 32'(mem_we_o), 32'h0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    check("rst_wb_reg_write", 32'(wb_reg_write_o), 32'h0);
    check("rst_misaligned", 32'(misaligned_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_mem_be", 32'(mem_be_o), 32'h0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_wb_rd", 32'(wb_rd_o), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ALU op retires next cycle without stalling
    push_wb(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
    run(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 3'b010, st);
    check("alu_stalls", 32'(st), 32'd0);

    // SB to byte lane 3, grant after two REQ cycles
    gnt_delay = 2;
    push_mem(32'h0000_0100, 1'b1, 4'b1000, 32'hAB00_0000);
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, st);
    check("sb_stalls", 32'(st), 32'd3);

    // LB / LBU from lane 2, response three cycles after grant
    gnt_delay = 0; rv_delay = 3; next_rdata = 32'h0080_0000;
    push_mem(32'h0000_0100, 1'b0, 4'b0100, 32'h0);
    push_wb(32'hFFFF_FF80, 5'd6, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b000, st);
    check("lb_stalls", 32'(st), 32'd4);
    push_mem(32'h0000_0100, 1'b0, 4'b0100, 32'h0);
    push_wb(32'h0000_0080, 5'd6, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b100, st);

    // Misaligned LH: no request, one-cycle pulse, then an ALU op
    r0 = req_seen;
    push_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    run(32'h0000_0101, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001, st);
    check("lh_mis_stalls", 32'(st), 32'd0);
    push_wb(32'h0000_A5A5, 5'd3, 1'b1, 1'b0, 1'b1);
    run(32'h0000_A5A5, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 3'b010, st);
    check("lh_mis_no_req", 32'(req_seen), 32'(r0));

    // SH upper half, immediate grant
    rv_delay = 1;
    push_mem(32'h0000_0100, 1'b1, 4'b1100, 32'hBEEF_0000);
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(32'h0000_0102, 32'h1234_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 3'b001, st);
    check("sh_stalls", 32'(st), 32'd1);

    // ld and st both set behaves as SW
    gnt_delay = 1;
    push_mem(32'h0000_0204, 1'b1, 4'b1111, 32'hCAFE_F00D);
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(32'h0000_0204, 32'hCAFE_F00D, 5'd4, 1'b1, 1'b1, 1'b1, 3'b010, st);
    check("ldst_stalls", 32'(st), 32'd2);

    // LH signed with stray rvalid during REQ and on the grant cycle
    junk_rv = 1; next_rdata = 32'h8001_0000;
    push_mem(32'h0000_0100, 1'b0, 4'b1100, 32'h0);
    push_wb(32'hFFFF_8001, 5'd11, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0102, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 3'b001, st);
    check("lh_junk_stalls", 32'(st), 32'd3);
    junk_rv = 0;

    // LHU low half
    gnt_delay = 0; next_rdata = 32'h1234_F00F;
    push_mem(32'h0000_0100, 1'b0, 4'b0011, 32'h0);
    push_wb(32'h0000_F00F, 5'd12, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0100, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 3'b101, st);
    check("lhu_stalls", 32'(st), 32'd2);

    // LW to x0: write enable suppressed
    next_rdata = 32'h1111_2222;
    push_mem(32'h0000_0010, 1'b0, 4'b1111, 32'h0);
    push_wb(32'h1111_2222, 5'd0, 1'b0, 1'b0, 1'b1);
    run(32'h0000_0010, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 3'b010, st);

    // Back-to-back LW then ALU: program order preserved
    rv_delay = 2; next_rdata = 32'h1234_5678;
    push_mem(32'h0000_0010, 1'b0, 4'b1111, 32'h0);
    push_wb(32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0010, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b010, st);
    check("lw_b2b_stalls", 32'(st), 32'd3);
    push_wb(32'h0000_0099, 5'd8, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0099, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 3'b010, st);

    // Misaligned SW
    push_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    run(32'h0000_0206, 32'h5555_5555, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010, st);

    // Reset while waiting for load data; its late response must be ignored
    gnt_delay = 0; rv_delay = 4; next_rdata = 32'h0BAD_F00D;
    push_mem(32'h0000_0200, 1'b0, 4'b1111, 32'h0);
    drive(32'h0000_0200, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(32'h0000_0300, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 3'b010);
    @(negedge clk); #1;
    check("rst_wait_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_wait_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("rst_hold_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_hold_wb_valid", 32'(wb_valid_o), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rv_delay = 2; next_rdata = 32'hFEDC_BA98;
    push_mem(32'h0000_0300, 1'b0, 4'b1111, 32'h0);
    push_wb(32'hFEDC_BA98, 5'd10, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("post_rst_idle_stall", 32'(stall_o), 32'h1);
    check("post_rst_mem_req", 32'(mem_req_o), 32'h0);
    check("post_rst_wb_valid", 32'(wb_valid_o), 32'h0);
    wait_accept(st);
    check("post_rst_lw_stalls", 32'(st), 32'd2);

    push_wb(32'h0000_0055, 5'd2, 1'b1, 1'b0, 1'b1);
    run(32'h0000_0055, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 3'b010, st);

    reset_n = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes its registered ALU result, store data, load/store controls and funct3 width.
- Performs loads and stores over a request/grant/response data-memory port, aligns and sign-extends load data, and registers the write-back bundle for the WB stage.
- Stalls the pipeline front while a memory transaction is outstanding.

Parameters:
- WD_SIZE, 32, data/address width.
- REG_SIZE, 5, register index width.
- FUNCT3_SIZE, 3, memory width code width.
- BE_SIZE, WD_SIZE/8, byte-enable width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- alu_result_i  in  WD_SIZE  effective address, or ALU result for non-memory ops.
- rs2_data_i  in  WD_SIZE  store data.
- rd_i  in  REG_SIZE  destination register.
- ctrl_ld_i  in  1  load.
- ctrl_st_i  in  1  store.
- ctrl_reg_write_i  in  1  instruction writes rd.
- ctrl_mem_width_i  in  FUNCT3_SIZE  000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall_o  out  1  hold upstream registers this cycle (combinational).
- mem_req_o  out  1  request valid.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  WD_SIZE  word-aligned address (low 2 bits 0).
- mem_wdata_o  out  WD_SIZE  lane-shifted store data.
- mem_be_o  out  BE_SIZE  byte enables.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  WD_SIZE  load word.
- wb_data_o  out  WD_SIZE  write-back value.
- wb_rd_o  out  REG_SIZE  write-back register.
- wb_reg_write_o  out  1  write enable.
- wb_valid_o  out  1  instruction retires this cycle.
- misaligned_o  out  1  one-cycle pulse: misaligned access dropped.

Behaviour:
- FSM states: IDLE, REQ, WAIT.
- Reset:
  - state IDLE.
  - mem_req_o, mem_we_o, wb_reg_write_o, wb_valid_o, misaligned_o = 0.
  - mem_addr_o, mem_wdata_o, mem_be_o, wb_data_o, wb_rd_o = 0.
- IDLE, non-memory op:
  - 1-cycle latency.
  - wb_data_o<=alu_result_i, wb_rd_o<=rd_i, wb_reg_write_o<=ctrl_reg_write_i, wb_valid_o<=1.
  - stall_o=0.
- IDLE, ld or st:
  - Alignment check: H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned: no memory access; misaligned_o<=1, wb_valid_o<=1, wb_reg_write_o<=0; stall_o=0.
  - Aligned: latch address/width/rd/data; drive mem_addr_o={addr[31:2],2'b00}.
    - mem_be_o: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
    - mem_wdata_o = rs2_data_i shifted left by 8*addr[1:0] (B/H replicated into lanes).
    - mem_we_o = ctrl_st_i.
    - Next state REQ; stall_o=1; wb_valid_o<=0, wb_reg_write_o<=0 (bubble).
- REQ:
  - mem_req_o=1; address, data, be and we held stable until mem_gnt_i.
  - No gnt: stall_o=1, bubble.
  - gnt on store: transaction complete; stall_o=0; wb_valid_o<=1, wb_reg_write_o<=0; next IDLE.
  - gnt on load: next WAIT; stall_o=1.
- WAIT:
  - mem_req_o=0; stall_o=1 until mem_rvalid_i.
  - On rvalid: stall_o=0.
  - Select byte/half by latched addr[1:0]; sign-extend (B,H) or zero-extend (BU,HU); W passes through.
  - wb_data_o<=result, wb_rd_o<=latched rd, wb_reg_write_o<=latched ctrl_reg_write, wb_valid_o<=1; next IDLE.
- ctrl_ld_i and ctrl_st_i both set: treated as store.
- Load to rd=0: wb_reg_write_o forced 0.
- mem_rvalid_i while in IDLE or REQ: ignored.
- mem_gnt_i and mem_rvalid_i in the same cycle during REQ: only gnt is consumed; response must arrive in a later cycle.
- Reset mid-transaction: return to IDLE, drop mem_req_o immediately; any late rvalid after reset is ignored.
- Upstream holds all inputs constant while stall_o=1.

Test Plan:
- ALU op alu_result_i=0x0000_1234, rd_i=5, reg_write=1 -> next cycle wb_data_o=0x1234, wb_rd_o=5, wb_reg_write_o=1, wb_valid_o=1, stall_o=0 throughout.
- SB addr 0x103, rs2=0xAB, gnt after 2 cycles -> mem_addr_o=0x100, mem_be_o=1000, mem_wdata_o[31:24]=0xAB, mem_we_o=1; stall_o high 3 cycles; wb_valid_o=1, wb_reg_write_o=0.
- LB addr 0x102, rdata=0x0080_0000, gnt immediate, rvalid 3 cycles later -> wb_data_o=0xFFFF_FF80; with LBU -> 0x0000_0080.
- LH addr 0x101 -> no mem_req_o ever, misaligned_o pulses 1 cycle, wb_reg_write_o=0.
- LW addr 0x200 with reset_n driven 0 while in WAIT -> mem_req_o=0, state IDLE, stall_o=0; rvalid arriving after reset produces no wb_valid_o.
- Back-to-back LW 0x10 then ALU op -> ALU result retires only after the load's wb_valid_o cycle, in program order, with no ALU result lost or duplicated.
